aes_key_fetch: RTL and testbench

//  Read-side controller for the AES-XTS-256 key memory. On a slot request it

---
 rtl/aes_key_fetch.sv | 139 +++++++++++++
 tb/tb_aes_key_fetch.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_fetch.sv
// Read-side controller for the AES-XTS-256 key memory: fetches the data/tweak
// key pair of a slot and presents it through a valid/ready handshake, with a one-entry slot cache.
module aes_key_fetch #(
   parameter int KEY_W  = 256,
   parameter int ADDR_W = 4
) (
   input  logic              inClk,
   input  logic              inRstN,
   input  logic              inReqValid,
   input  logic [ADDR_W-2:0] inReqSlot,
   output logic              outReqReady,
   input  logic              inInvalidate,
   output logic              outMemRd,
   output logic [ADDR_W-1:0] outMemAddr,
   input  logic [KEY_W-1:0]  inMemData,
   output logic              outKeyValid,
   input  logic              inKeyReady,
   output logic [KEY_W-1:0]  outDataKey,
   output logic [KEY_W-1:0]  outTweakKey,
   output logic [ADDR_W-2:0] outKeySlot
);

   typedef enum logic [2:0] {
      IDLE,
      RD0,
      RD1,
      CAP,
      HOLD
   } fetchStateT;

   fetchStateT        state;
   fetchStateT        nextState;

   logic [ADDR_W-2:0] reqSlot;
   logic [ADDR_W-2:0] cachedSlot;
   logic              cacheValid;
   logic              invPending;
   logic              reqReady;
   logic [ADDR_W-1:0] memAddr;
   logic [KEY_W-1:0]  dataKey;
   logic [KEY_W-1:0]  tweakKey;
   logic [ADDR_W-2:0] keySlot;

   logic              accept;
   logic              cacheHit;

   assign accept   = inReqValid & reqReady;
   assign cacheHit = cacheValid & (inReqSlot == cachedSlot) & ~inInvalidate;

   // NOTE: reset is synchronous, so it is tested only inside the clocked block, never in the sensitivity list.
   always_ff @(posedge inClk) begin
      if (!inRstN) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // NOTE: combinational blocks assign a default first so no path leaves a signal unassigned (no latch).
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (accept) begin
               nextState = cacheHit ? HOLD : RD0;
            end
         end
         RD0:  nextState = RD1;
         RD1:  nextState = CAP;
         CAP:  nextState = HOLD;
         HOLD: begin
            if (inKeyReady) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // The key output registers double as the cache data: whenever the cache is valid,
   // the last delivered pair is exactly the cached slot's pair.
   // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge inClk) begin
      if (!inRstN) begin
         reqSlot    <= '0;
         cachedSlot <= '0;
         cacheValid <= 1'b0;
         invPending <= 1'b0;
         reqReady   <= 1'b0;
         memAddr    <= '0;
         dataKey    <= '0;
         tweakKey   <= '0;
         keySlot    <= '0;
      end else begin
         reqReady <= (nextState == IDLE);

         if (state == IDLE && accept) begin
            reqSlot    <= inReqSlot;
            invPending <= 1'b0;
            if (!cacheHit) begin
               memAddr <= {inReqSlot, 1'b0};
            end
         end

         if (state == RD0) begin
            memAddr <= {reqSlot, 1'b1};
         end

         if (state == RD1) begin
            dataKey <= inMemData;
         end

         // A write to key memory during the fetch makes the pair stale for caching purposes.
         if ((state == RD0 || state == RD1 || state == CAP) && inInvalidate) begin
            invPending <= 1'b1;
         end

         if (state == CAP) begin
            tweakKey   <= inMemData;
            keySlot    <= reqSlot;
            cachedSlot <= reqSlot;
            cacheValid <= ~(invPending | inInvalidate);
         end else if (inInvalidate) begin
            cacheValid <= 1'b0;
         end
      end
   end

   always_comb begin
      outReqReady = reqReady;
      outMemRd    = (state == RD0) || (state == RD1);
      outMemAddr  = memAddr;
      outKeyValid = (state == HOLD);
      outDataKey  = dataKey;
      outTweakKey = tweakKey;
      outKeySlot  = keySlot;
   end

endmodule

// File: tb/tb_aes_key_fetch.sv
// Self-checking bench for aes_key_fetch: a behavioural key memory plus a slot-cache
// reference model, directed scenarios followed by randomized request sequences.
module tb_aes_key_fetch;

   localparam int KEY_W  = 256;
   localparam int ADDR_W = 4;

   logic              inClk        = 1'b0;
   logic              inRstN       = 1'b0;
   logic              inReqValid   = 1'b0;
   logic [ADDR_W-2:0] inReqSlot    = '0;
   logic              inInvalidate = 1'b0;
   logic              inKeyReady   = 1'b0;
   logic [KEY_W-1:0]  inMemData;
   logic              outReqReady;
   logic              outMemRd;
   logic [ADDR_W-1:0] outMemAddr;
   logic              outKeyValid;
   logic [KEY_W-1:0]  outDataKey;
   logic [KEY_W-1:0]  outTweakKey;
   logic [ADDR_W-2:0] outKeySlot;

   logic [KEY_W-1:0]  mem [2**ADDR_W];
   logic [KEY_W-1:0]  memQ;

   int nChecks = 0;
   int nFails  = 0;

   // Reference cache model: which slot, if any, should be served without a fetch.
   bit                modelValid = 1'b0;
   logic [ADDR_W-2:0] modelSlot  = '0;

   // Results of the last request driven by doReq.
   int               lat;
   int               nRd;
   int               rdAddr [2];
   logic [KEY_W-1:0] gotData;
   logic [KEY_W-1:0] gotTweak;
   logic [ADDR_W-2:0] gotSlot;

   aes_key_fetch #(.KEY_W(KEY_W), .ADDR_W(ADDR_W)) dut (
      .inClk        (inClk),
      .inRstN       (inRstN),
      .inReqValid   (inReqValid),
      .inReqSlot    (inReqSlot),
      .outReqReady  (outReqReady),
      .inInvalidate (inInvalidate),
      .outMemRd     (outMemRd),
      .outMemAddr   (outMemAddr),
      .inMemData    (inMemData),
      .outKeyValid  (outKeyValid),
      .inKeyReady   (inKeyReady),
      .outDataKey   (outDataKey),
      .outTweakKey  (outTweakKey),
      .outKeySlot   (outKeySlot)
   );

   always #5 inClk = ~inClk;

   // Key memory with one cycle of registered read latency; data is X when not read.
   always @(posedge inClk) memQ <= outMemRd ? mem[outMemAddr] : 'x;
   assign inMemData = memQ;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1);
   end

   function automatic logic [KEY_W-1:0] randKey();
      logic [KEY_W-1:0] k;
      for (int i = 0; i < KEY_W/32; i++) k[i*32 +: 32] = $urandom;
      return k;
   endfunction

   // Drives one request (called at a negedge) and observes until outKeyValid or a cycle budget.
   // invCycle: cycle after accept (0 = accept cycle) in which inInvalidate pulses, -1 for none.
   task automatic doReq(input logic [ADDR_W-2:0] slot, input int invCycle);
      int waitCyc = 0;
      lat = 0; nRd = 0; rdAddr[0] = -1; rdAddr[1] = -1;
      inReqValid = 1'b1; inReqSlot = slot; inInvalidate = (invCycle == 0);
      while (!outReqReady && waitCyc < 20) begin
         @(negedge inClk); waitCyc++;
      end
      @(posedge inClk); @(negedge inClk);
      inReqValid = 1'b0; inInvalidate = 1'b0; lat = 1;
      while (!outKeyValid && lat < 20) begin
         if (outMemRd) begin
            if (nRd < 2) rdAddr[nRd] = int'(outMemAddr);
            nRd++;
         end
         inInvalidate = (invCycle == lat);
         @(negedge inClk); lat++;
         inInvalidate = 1'b0;
      end
      gotData = outDataKey; gotTweak = outTweakKey; gotSlot = outKeySlot;
   endtask

   task automatic consume();
      inKeyReady = 1'b1;
      @(posedge inClk); @(negedge inClk);
      inKeyReady = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge inClk); @(negedge inClk);
      nChecks++; if (outKeyValid !== 1'b0) begin nFails++; $display("FAIL reset_valid: got %b want 0", outKeyValid); end
      nChecks++; if (outMemRd !== 1'b0) begin nFails++; $display("FAIL reset_rd: got %b want 0", outMemRd); end
      nChecks++; if (outMemAddr !== '0) begin nFails++; $display("FAIL reset_addr: got %0d want 0", outMemAddr); end
      nChecks++; if (outDataKey !== '0 || outTweakKey !== '0) begin nFails++; $display("FAIL reset_keys: got %h / %h want 0", outDataKey, outTweakKey); end
      nChecks++; if (outKeySlot !== '0) begin nFails++; $display("FAIL reset_slot: got %0d want 0", outKeySlot); end
      nChecks++; if (outReqReady !== 1'b0) begin nFails++; $display("FAIL reset_ready: got %b want 0", outReqReady); end
      inRstN = 1'b1;
      @(negedge inClk);
      nChecks++; if (outReqReady !== 1'b1) begin nFails++; $display("FAIL post_reset_ready: got %b want 1", outReqReady); end
      nChecks++; if (outMemRd !== 1'b0) begin nFails++; $display("FAIL post_reset_rd: got %b want 0", outMemRd); end
   endtask

   task automatic test_miss();
      mem[6] = randKey(); mem[7] = randKey();
      doReq(3'd3, -1);
      nChecks++; if (lat !== 4) begin nFails++; $display("FAIL miss_latency: got %0d want 4", lat); end
      nChecks++; if (nRd !== 2 || rdAddr[0] !== 6 || rdAddr[1] !== 7) begin nFails++; $display("FAIL miss_reads: got n=%0d addr %0d,%0d want n=2 addr 6,7", nRd, rdAddr[0], rdAddr[1]); end
      nChecks++; if (gotData !== mem[6]) begin nFails++; $display("FAIL miss_data_key: got %h want %h", gotData, mem[6]); end
      nChecks++; if (gotTweak !== mem[7]) begin nFails++; $display("FAIL miss_tweak_key: got %h want %h", gotTweak, mem[7]); end
      nChecks++; if (gotSlot !== 3'd3) begin nFails++; $display("FAIL miss_slot: got %0d want 3", gotSlot); end
      consume();
      nChecks++; if (outKeyValid !== 1'b0 || outReqReady !== 1'b1) begin nFails++; $display("FAIL miss_release: got valid=%b ready=%b want 0/1", outKeyValid, outReqReady); end
      modelValid = 1'b1; modelSlot = 3'd3;
   endtask

   task automatic test_hit();
      doReq(3'd3, -1);
      nChecks++; if (lat !== 1) begin nFails++; $display("FAIL hit_latency: got %0d want 1", lat); end
      nChecks++; if (nRd !== 0) begin nFails++; $display("FAIL hit_reads: got %0d want 0", nRd); end
      nChecks++; if (outMemAddr !== 4'd7) begin nFails++; $display("FAIL hit_addr_held: got %0d want 7", outMemAddr); end
      nChecks++; if (gotData !== mem[6] || gotTweak !== mem[7] || gotSlot !== 3'd3) begin nFails++; $display("FAIL hit_pair: got %h / %h slot %0d", gotData, gotTweak, gotSlot); end
      consume();
   endtask

   task automatic test_invalidate();
      mem[10] = randKey(); mem[11] = randKey();
      doReq(3'd5, 2);
      nChecks++; if (lat !== 4 || gotData !== mem[10] || gotTweak !== mem[11]) begin nFails++; $display("FAIL inv_delivery: got lat %0d keys %h / %h", lat, gotData, gotTweak); end
      consume();
      mem[10] = randKey(); mem[11] = randKey();
      doReq(3'd5, -1);
      nChecks++; if (nRd !== 2 || rdAddr[0] !== 10 || rdAddr[1] !== 11) begin nFails++; $display("FAIL inv_refetch: got n=%0d addr %0d,%0d want n=2 addr 10,11", nRd, rdAddr[0], rdAddr[1]); end
      nChecks++; if (gotData !== mem[10] || gotTweak !== mem[11]) begin nFails++; $display("FAIL inv_new_keys: got %h / %h want %h / %h", gotData, gotTweak, mem[10], mem[11]); end
      consume();
      doReq(3'd5, 0);
      nChecks++; if (lat !== 4 || nRd !== 2) begin nFails++; $display("FAIL inv_on_accept: got lat %0d reads %0d want 4/2", lat, nRd); end
      consume();
      modelValid = 1'b1; modelSlot = 3'd5;
   endtask

   task automatic test_backpressure();
      doReq(3'd5, -1);
      nChecks++; if (lat !== 1) begin nFails++; $display("FAIL bp_hit_latency: got %0d want 1", lat); end
      inReqValid = 1'b1; inReqSlot = 3'd2;
      for (int i = 0; i < 5; i++) begin
         @(negedge inClk);
         nChecks++; if (outKeyValid !== 1'b1 || outReqReady !== 1'b0) begin nFails++; $display("FAIL bp_hold_%0d: got valid=%b ready=%b want 1/0", i, outKeyValid, outReqReady); end
         nChecks++; if (outDataKey !== mem[10] || outTweakKey !== mem[11] || outKeySlot !== 3'd5 || outMemRd !== 1'b0) begin nFails++; $display("FAIL bp_stable_%0d: got slot %0d rd %b keys %h / %h", i, outKeySlot, outMemRd, outDataKey, outTweakKey); end
      end
      inReqValid = 1'b0;
      consume();
      nChecks++; if (outKeyValid !== 1'b0 || outReqReady !== 1'b1) begin nFails++; $display("FAIL bp_release: got valid=%b ready=%b want 0/1", outKeyValid, outReqReady); end
      nChecks++; if (outDataKey !== mem[10] || outTweakKey !== mem[11]) begin nFails++; $display("FAIL bp_idle_keys: got %h / %h", outDataKey, outTweakKey); end
   endtask

   task automatic test_reset_mid_fetch();
      bit seen = 1'b0;
      doReq(3'd3, -1);
      consume();
      inReqValid = 1'b1; inReqSlot = 3'd1;
      @(posedge inClk); @(negedge inClk);
      inReqValid = 1'b0;
      @(negedge inClk);
      nChecks++; if (outMemRd !== 1'b1 || outMemAddr !== 4'd3) begin nFails++; $display("FAIL rst_mid_in_rd1: got rd=%b addr=%0d want 1/3", outMemRd, outMemAddr); end
      inRstN = 1'b0;
      @(negedge inClk);
      inRstN = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (outKeyValid) seen = 1'b1;
         @(negedge inClk);
      end
      nChecks++; if (seen !== 1'b0) begin nFails++; $display("FAIL rst_mid_no_delivery: got valid seen=%b want 0", seen); end
      nChecks++; if (outDataKey !== '0 || outKeySlot !== '0) begin nFails++; $display("FAIL rst_mid_cleared: got slot %0d key %h want 0", outKeySlot, outDataKey); end
      modelValid = 1'b0;
      doReq(3'd3, -1);
      nChecks++; if (lat !== 4 || nRd !== 2 || gotData !== mem[6] || gotTweak !== mem[7]) begin nFails++; $display("FAIL rst_mid_refetch: got lat %0d reads %0d", lat, nRd); end
      consume();
      modelValid = 1'b1; modelSlot = 3'd3;
   endtask

   task automatic test_random();
      for (int it = 0; it < 40; it++) begin
         logic [ADDR_W-2:0] s;
         int r;
         int inv;
         bit expHit;
         int stall;
         if ($urandom_range(4) == 0) begin
            int w;
            w = $urandom_range(7);
            mem[2*w] = randKey(); mem[2*w+1] = randKey();
            inInvalidate = 1'b1;
            @(negedge inClk);
            inInvalidate = 1'b0;
            modelValid = 1'b0;
         end
         s = $urandom_range(1) ? modelSlot : ADDR_W'($urandom_range(7)) >> 0;
         r = $urandom_range(7);
         inv = (r < 4) ? -1 : r - 4;
         expHit = modelValid && (s == modelSlot) && (inv != 0);
         doReq(s, inv);
         nChecks++; if (lat !== (expHit ? 1 : 4) || nRd !== (expHit ? 0 : 2)) begin nFails++; $display("FAIL rnd_%0d_timing: slot %0d got lat %0d reads %0d want hit=%b", it, s, lat, nRd, expHit); end
         if (!expHit) begin
            nChecks++; if (rdAddr[0] !== 2*int'(s) || rdAddr[1] !== 2*int'(s)+1) begin nFails++; $display("FAIL rnd_%0d_addr: got %0d,%0d want %0d,%0d", it, rdAddr[0], rdAddr[1], 2*int'(s), 2*int'(s)+1); end
            modelValid = !(inv >= 1 && inv <= 3);
            modelSlot = s;
         end
         nChecks++; if (gotData !== mem[2*s] || gotTweak !== mem[2*s+1] || gotSlot !== s) begin nFails++; $display("FAIL rnd_%0d_pair: slot %0d got slot %0d keys %h / %h", it, s, gotSlot, gotData, gotTweak); end
         stall = $urandom_range(2);
         for (int k = 0; k < stall; k++) @(negedge inClk);
         nChecks++; if (outKeyValid !== 1'b1) begin nFails++; $display("FAIL rnd_%0d_stall: got valid %b want 1", it, outKeyValid); end
         consume();
         nChecks++; if (outKeyValid !== 1'b0) begin nFails++; $display("FAIL rnd_%0d_drop: got valid %b want 0", it, outKeyValid); end
      end
   endtask

   initial begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] = randKey();
      test_reset();
      test_miss();
      test_hit();
      test_invalidate();
      test_backpressure();
      test_reset_mid_fetch();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
